// File: rtl/gpio_octal_controller.sv
// Register-programmable control/observation stage for the octal tristate pad block.
// Drives PadOut/PadOE from software registers. Synchronizes and debounces PadIn,
// detects edges, and collects per-bit sticky status into one level interrupt.
//
// Ports:
//   Clk, Reset_n        - system clock (rising edge), asynchronous active-low reset
//   Addr, WrEn, WrData  - register write port (one cycle strobe)
//   RdEn, RdData, RdValid - register read port, data/valid one cycle after RdEn
//   PadIn               - asynchronous input bus from the pad block
//   PadOut, PadOE       - output data and drive enables to the pad block (1 = drive)
//   Irq                 - OR of pending status bits masked by IRQ_EN
//
// Register map: 0 DATA_OUT, 1 DIR, 2 DATA_IN (RO), 3 IRQ_EN, 4 RISE_EN,
//               5 FALL_EN, 6 IRQ_STAT (W1C), 7 reserved.
module gpio_octal_controller #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] Addr,
  input  logic       WrEn,
  input  logic [7:0] WrData,
  input  logic       RdEn,
  output logic [7:0] RdData,
  output logic       RdValid,
  input  logic [7:0] PadIn,
  output logic [7:0] PadOut,
  output logic [7:0] PadOE,
  output logic       Irq
);

  localparam int unsigned NUM_BITS = 8;
  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd6;

  logic [NUM_BITS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BITS-1:0] sync_s;

  logic [CNT_W-1:0]    cnt_q  [NUM_BITS];
  logic [CNT_W-1:0]    cnt_d  [NUM_BITS];
  logic [NUM_BITS-1:0] deb_q;
  logic [NUM_BITS-1:0] toggle;

  logic [NUM_BITS-1:0] irq_en_q;
  logic [NUM_BITS-1:0] rise_en_q;
  logic [NUM_BITS-1:0] fall_en_q;
  logic [NUM_BITS-1:0] irq_stat_q;
  logic [NUM_BITS-1:0] irq_stat_d;
  logic [NUM_BITS-1:0] stat_clr;
  logic [NUM_BITS-1:0] stat_set;
  logic [NUM_BITS-1:0] rd_mux;

  // Input synchronizer: plain flop chain, no logic between stages.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= PadIn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce next-state: value flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    toggle = '0;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      cnt_d[i]  = '0;
      toggle[i] = (sync_s[i] != deb_q[i]) && (cnt_q[i] == CNT_LAST);
      if ((sync_s[i] != deb_q[i]) && !toggle[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < NUM_BITS; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_q ^ toggle;
      for (int unsigned i = 0; i < NUM_BITS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Edge events land on the same edge the debounced value changes; set beats W1C clear.
  always_comb begin
    stat_set   = toggle & ((~deb_q & rise_en_q) | (deb_q & fall_en_q));
    stat_clr   = (WrEn && (Addr == ADDR_IRQ_STAT)) ? WrData : '0;
    irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
  end

  // Software-writable registers; writes to DATA_IN and reserved fall through.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PadOut     <= '0;
      PadOE      <= '0;
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
    end else begin
      irq_stat_q <= irq_stat_d;
      if (WrEn) begin
        case (Addr)
          ADDR_DATA_OUT: PadOut    <= WrData;
          ADDR_DIR:      PadOE     <= WrData;
          ADDR_IRQ_EN:   irq_en_q  <= WrData;
          ADDR_RISE_EN:  rise_en_q <= WrData;
          ADDR_FALL_EN:  fall_en_q <= WrData;
          default: ;
        endcase
      end
    end
  end

  // Read mux samples pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (Addr)
      ADDR_DATA_OUT: rd_mux = PadOut;
      ADDR_DIR:      rd_mux = PadOE;
      ADDR_DATA_IN:  rd_mux = deb_q;
      ADDR_IRQ_EN:   rd_mux = irq_en_q;
      ADDR_RISE_EN:  rd_mux = rise_en_q;
      ADDR_FALL_EN:  rd_mux = fall_en_q;
      ADDR_IRQ_STAT: rd_mux = irq_stat_q;
      default:       rd_mux = '0;
    endcase
  end

  // Registered read port; RdData holds while idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) RdData <= rd_mux;
    end
  end

  // Interrupt is a pure function of registered state.
  assign Irq = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_octal_controller.sv
// Self-checking bench for gpio_octal_controller: table-driven register vectors,
// hand-written debounce/interrupt sequences, and a read-data scoreboard.
module tb_gpio_octal_controller;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [2:0] Addr;
  logic       WrEn;
  logic [7:0] WrData;
  logic       RdEn;
  logic [7:0] RdData;
  logic       RdValid;
  logic [7:0] PadIn;
  logic [7:0] PadOut;
  logic [7:0] PadOE;
  logic       Irq;

  int checks = 0;
  int errors = 0;

  gpio_octal_controller #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .WrEn(WrEn), .WrData(WrData),
    .RdEn(RdEn), .RdData(RdData), .RdValid(RdValid), .PadIn(PadIn),
    .PadOut(PadOut), .PadOE(PadOE), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } rd_exp_t;

  vec_t    vecs[$];
  rd_exp_t sb[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every RdValid pops the oldest expected read.
  always @(negedge Clk) begin
    rd_exp_t e;
    if (Reset_n === 1'b1 && RdValid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got %02h expected no RdValid at %0t", RdData, $time);
      end else begin
        e = sb.pop_front();
        check8($sformatf("rd_addr%0d", e.addr), RdData, e.data);
      end
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    Addr = a; WrData = d; WrEn = 1'b1;
    cycle();
    WrEn = 1'b0;
  endtask

  task automatic read(input logic [2:0] a, input logic [7:0] exp);
    Addr = a; RdEn = 1'b1;
    sb.push_back('{addr: a, data: exp});
    cycle();
    RdEn = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    Reset_n = 1'b0; Addr = '0; WrEn = 1'b0; WrData = '0; RdEn = 1'b0; PadIn = '0;

    // Register vectors (PadIn idle low, so no status activity).
    vecs.push_back('{1'b1, 1'b0, 3'd0, 8'hA5, 8'h00, 8'hA5, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 8'h0F, 8'h00, 8'hA5, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 8'h00, 8'h0F, 8'hA5, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 8'h00, 8'hA5, 8'hA5, 8'h0F});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 8'h3C, 8'hA5, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 8'h00, 8'h3C, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 8'h55, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h00, 8'h55, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 8'hAA, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 8'h00, 8'hAA, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 8'h33, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd5, 8'h00, 8'h33, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd7, 8'hFF, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'hFF, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b0, 1'b1, 3'd6, 8'h00, 8'h00, 8'h3C, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 8'hC3, 8'h00, 8'h3C, 8'hC3});

    #12;
    check8("rst_padout", PadOut, 8'h00);
    check8("rst_padoe", PadOE, 8'h00);
    check8("rst_rdvalid", {7'd0, RdValid}, 8'h00);
    check8("rst_irq", {7'd0, Irq}, 8'h00);
    Reset_n = 1'b1;
    cycle();

    foreach (vecs[i]) begin
      Addr = vecs[i].addr; WrData = vecs[i].wdata;
      WrEn = vecs[i].wr;   RdEn = vecs[i].rd;
      if (vecs[i].rd) sb.push_back('{addr: vecs[i].addr, data: vecs[i].exp_rd});
      cycle();
      WrEn = 1'b0; RdEn = 1'b0;
      check8($sformatf("vec%0d_padout", i), PadOut, vecs[i].exp_out);
      check8($sformatf("vec%0d_padoe", i), PadOE, vecs[i].exp_oe);
    end

    // RdValid is a single-cycle pulse and RdData holds afterwards.
    read(3'd1, 8'hC3);
    cycle();
    check8("rdvalid_drop", {7'd0, RdValid}, 8'h00);
    check8("rddata_hold", RdData, 8'hC3);

    // Asynchronous reset mid-run clears outputs immediately.
    Reset_n = 1'b0;
    #1;
    check8("midrst_padout", PadOut, 8'h00);
    check8("midrst_padoe", PadOE, 8'h00);
    check8("midrst_rdvalid", {7'd0, RdValid}, 8'h00);
    check8("midrst_irq", {7'd0, Irq}, 8'h00);
    #2;
    Reset_n = 1'b1;
    cycle();
    for (int a = 0; a < 8; a++) read(3'(a), 8'h00);

    // Glitch of three clocks never reaches DATA_IN.
    PadIn = 8'h08;
    idle(3);
    PadIn = 8'h00;
    idle(8);
    read(3'd2, 8'h00);

    // Stable rise: DATA_IN updates six edges after the change, status and Irq follow.
    write(3'd4, 8'h08);
    write(3'd3, 8'h08);
    PadIn = 8'h08;
    idle(4);
    read(3'd2, 8'h00);
    idle(2);
    read(3'd2, 8'h08);
    read(3'd6, 8'h08);
    check8("irq_rise", {7'd0, Irq}, 8'h01);
    write(3'd6, 8'h08);
    check8("irq_cleared", {7'd0, Irq}, 8'h00);
    read(3'd6, 8'h00);

    // Masking leaves status pending.
    write(3'd5, 8'h08);
    PadIn = 8'h00;
    idle(10);
    read(3'd6, 8'h08);
    check8("irq_fall", {7'd0, Irq}, 8'h01);
    write(3'd3, 8'h00);
    check8("irq_masked", {7'd0, Irq}, 8'h00);
    read(3'd6, 8'h08);
    write(3'd6, 8'hFF);
    read(3'd6, 8'h00);

    // Set and W1C on the same edge: set wins.
    write(3'd4, 8'h01);
    PadIn = 8'h01;
    idle(5);
    write(3'd6, 8'h01);
    read(3'd6, 8'h01);
    check8("irq_collide_masked", {7'd0, Irq}, 8'h00);

    // Falling edge on bit 7 and writes to read-only/reserved addresses.
    write(3'd6, 8'hFF);
    PadIn = 8'h81;
    idle(10);
    write(3'd5, 8'h80);
    PadIn = 8'h01;
    idle(10);
    read(3'd6, 8'h80);
    write(3'd7, 8'hFF);
    write(3'd2, 8'hFF);
    read(3'd7, 8'h00);
    read(3'd2, 8'h01);

    idle(2);
    check8("sb_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_octal_controller.md
Name: gpio_octal_controller

Overview:
- Register-programmable control and observation stage for the octal tristate pad block.
- Upstream role: drives the pad block's per-bit Output data and OE enables from software-writable registers.
- Downstream role: consumes the pad block's Input bus. It synchronizes and debounces each bit, detects edges and latches per-bit interrupt status into one level interrupt.
- Sits between the system register bus and the pad block.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizer per bit (legal 2..4)
DEBOUNCE_CYCLES, 4, consecutive mismatching synchronized samples needed before the debounced value changes (legal 1..255)

Ports:
Clk  input  1  single system clock; all state on rising edge
Reset_n  input  1  asynchronous active-low reset
Addr  input  3  register address
WrEn  input  1  write strobe, one cycle per write
WrData  input  8  write data
RdEn  input  1  read strobe, one cycle per read
RdData  output  8  registered read data
RdValid  output  1  high one cycle after RdEn
PadIn  input  8  from pad block Input bus (asynchronous)
PadOut  output  8  to pad block Output bus
PadOE  output  8  to pad block OE bus (1 = drive)
Irq  output  1  level interrupt

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All registers, synchronizer flops, debounce counters and debounced values clear to 0.
  - PadOut=0, PadOE=0 (all pins high-Z), RdData=0, RdValid=0, Irq=0.
  - Reset asserted mid-debounce or mid-read discards that operation; no status survives.
- Register map (access type):
  - 0 DATA_OUT (RW): drives PadOut.
  - 1 DIR (RW): drives PadOE.
  - 2 DATA_IN (RO): debounced input value.
  - 3 IRQ_EN (RW): per-bit interrupt mask.
  - 4 RISE_EN (RW): per-bit rising-edge detect enable.
  - 5 FALL_EN (RW): per-bit falling-edge detect enable.
  - 6 IRQ_STAT (R/W1C).
  - 7 reserved: reads 0, writes ignored.
- Writes:
  - Take effect at the Clk edge where WrEn=1.
  - PadOut/PadOE change on that same edge (registered outputs, no combinational path from WrData).
  - Writes to 2 and 7 are ignored.
- Reads:
  - RdEn=1 at edge N gives RdValid=1 and RdData=register value sampled at edge N, both visible after edge N.
  - RdValid drops after edge N+1 unless RdEn is still high.
  - RdData holds its last value when RdValid=0.
  - Back-to-back reads are legal, one per cycle.
  - Simultaneous RdEn and WrEn to the same address returns the pre-write value.
- Synchronizer: per bit, a SYNC_STAGES-deep flop chain on PadIn; no logic between stages.
- Debounce (per bit):
  - Define s = synchronizer output and d = debounced value, with counter cnt.
  - If s==d: cnt clears to 0.
  - If s!=d and cnt==DEBOUNCE_CYCLES-1: d toggles and cnt clears.
  - Otherwise: cnt increments.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized samples never changes d.
  - Latency from a stable pad change to DATA_IN update: SYNC_STAGES+DEBOUNCE_CYCLES clocks (6 at defaults), ±1 for the asynchronous sampling edge.
- Edge detect and status:
  - A rise event fires on the edge where d goes 0->1 and RISE_EN bit=1.
  - A fall event fires where d goes 1->0 and FALL_EN bit=1.
  - Events set the IRQ_STAT bit on the same edge that d changes.
  - Status bits set regardless of IRQ_EN (IRQ_EN masks only Irq).
  - A write to 6 clears every bit where WrData=1.
  - If set and clear hit the same bit on the same edge, set wins.
  - Status is sticky until cleared.
- Irq = OR over bits of (IRQ_STAT & IRQ_EN). It is combinational from registers, so changing IRQ_EN updates Irq after that write edge.
- Output loopback: a driven pin (PadOE=1) is still observed through PadIn and can raise edge status; this is intentional.
- Bits are fully independent; no cross-bit interaction.

Test Plan:
- Reset/defaults: assert Reset_n low mid-run with registers nonzero -> PadOut=0x00, PadOE=0x00, Irq=0, RdValid=0 immediately; reading all 8 addresses after release returns 0x00.
- Output path: write 0xA5 to addr 0, 0x0F to addr 1 -> PadOut=0xA5, PadOE=0x0F after that edge; read addr 1 -> RdValid high one cycle later with RdData=0x0F.
- Debounce: hold PadIn[3] high for 3 clocks then low (defaults) -> DATA_IN stays 0x00. Hold it high for ≥6 clocks -> DATA_IN=0x08 within 6–7 clocks of the change.
- Interrupt: set RISE_EN=0x08, IRQ_EN=0x08, raise PadIn[3] stably -> IRQ_STAT=0x08 and Irq=1. Write 0x08 to addr 6 -> IRQ_STAT=0x00 and Irq=0 next cycle. Write IRQ_EN=0x00 while status is pending -> Irq=0 and status is retained.
- Set/clear collision: force bit 0 status to set on the same edge as a W1C write of 0x01 -> IRQ_STAT bit0=1 afterwards.
- Fall/reserved: FALL_EN=0x80, drop PadIn[7] from 1 to 0 -> IRQ_STAT=0x80. Write 0xFF to addr 7 and addr 2 -> reads of both unchanged (0x00, current DATA_IN).
